// File: rtl/reg_slice_pkg.sv
//------------------------------------------------------------------------------
// reg_slice_pkg : shared state encoding and occupancy helpers for reg_slice_skid
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_slice_pkg;

  localparam int OCC_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_slice_stage.sv
//------------------------------------------------------------------------------
// reg_slice_stage : load-enabled data register with synchronous reset value
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_slice_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_q <= RESET_VAL;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/reg_slice_skid.sv
//------------------------------------------------------------------------------
// reg_slice_skid : elastic valid/ready register slice with 2-entry skid buffer
// and synchronous flush. Optional stall counter under REG_SLICE_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_slice_skid
  import reg_slice_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
`ifdef REG_SLICE_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             w_in_xfer;
  logic             w_main_load;
  logic             w_skid_load;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_xfer = in_valid & r_in_ready;

  // Flush only moves the state; data registers keep whatever they held.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && out_ready) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  reg_slice_stage #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .Reset (Reset),
    .load  (w_main_load),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  reg_slice_stage #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .Reset (Reset),
    .load  (w_skid_load),
    .d     (in_data),
    .q     (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_data  = w_main_q;
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = occ_of(r_state);

`ifdef REG_SLICE_STATS_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of upstream cycles refused by backpressure.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_stall_cnt <= 32'd0;
    end else if (in_valid && !r_in_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_slice_skid.sv
//------------------------------------------------------------------------------
// tb_reg_slice_skid : directed vector table plus randomized queue-model check
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_slice_skid;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'hA5C3;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          flush = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
`ifdef REG_SLICE_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_slice_skid #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef REG_SLICE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_d;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [15:0] d, input logic ordy, input logic e_ov,
                              input logic e_ir, input logic [1:0] e_occ, input logic [15:0] e_d);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_d = e_d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] q[$];
    int unsigned m_stall;
    logic        m_ir;
    logic        m_ov;

    // rst fl iv data ordy | ov ir occ data
    vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, RV);
    vecs[1]  = mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, RV);
    vecs[2]  = mk(0, 0, 0, 16'h0000, 0, 0, 1, 0, RV);
    vecs[3]  = mk(0, 0, 1, 16'h0011, 1, 1, 1, 1, 16'h0011);
    vecs[4]  = mk(0, 0, 1, 16'h0022, 1, 1, 1, 1, 16'h0022);
    vecs[5]  = mk(0, 0, 1, 16'h0033, 1, 1, 1, 1, 16'h0033);
    vecs[6]  = mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0033);
    vecs[7]  = mk(0, 0, 1, 16'h00A0, 0, 1, 1, 1, 16'h00A0);
    vecs[8]  = mk(0, 0, 1, 16'h00B0, 0, 1, 0, 2, 16'h00A0);
    vecs[9]  = mk(0, 0, 1, 16'h00EE, 0, 1, 0, 2, 16'h00A0);
    vecs[10] = mk(0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h00B0);
    vecs[11] = mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h00B0);
    vecs[12] = mk(0, 0, 1, 16'h00C1, 0, 1, 1, 1, 16'h00C1);
    vecs[13] = mk(0, 0, 1, 16'h00C2, 0, 1, 0, 2, 16'h00C1);
    vecs[14] = mk(0, 1, 1, 16'h00CC, 1, 0, 1, 0, 16'h00C1);
    vecs[15] = mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h00C1);
    vecs[16] = mk(0, 0, 1, 16'h00D1, 0, 1, 1, 1, 16'h00D1);
    vecs[17] = mk(0, 0, 1, 16'h00D2, 0, 1, 0, 2, 16'h00D1);
    vecs[18] = mk(1, 1, 1, 16'h00D3, 1, 0, 1, 0, RV);
    vecs[19] = mk(0, 0, 1, 16'h0055, 1, 1, 1, 1, 16'h0055);
    vecs[20] = mk(0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0055);
    vecs[21] = mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0055);

    for (int i = 0; i < 22; i++) begin
      Reset     = vecs[i].rst;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d occupancy", i), {30'b0, occupancy}, {30'b0, vecs[i].e_occ});
      chk($sformatf("vec%0d out_data", i), {16'b0, out_data}, {16'b0, vecs[i].e_d});
    end

`ifdef REG_SLICE_STATS_EN
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("stats after reset", stall_cnt, 32'd0);
    Reset = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    chk("stats fill occupancy", {30'b0, occupancy}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      in_data = 16'h0100 + 16'(k);
      tick();
    end
    chk("stats five stalls", stall_cnt, 32'd5);
    flush = 1'b1;
    tick();
    chk("stats kept by flush", stall_cnt, 32'd5);
    chk("stats flush occupancy", {30'b0, occupancy}, 32'd0);
    flush = 1'b0; Reset = 1'b1;
    tick();
    chk("stats cleared by reset", stall_cnt, 32'd0);
`endif

    // Random phase: a plain FIFO of at most two entries is the reference.
    m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      Reset     = (c == 0) || ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);

      m_ir = (q.size() < 2);
      m_ov = (q.size() > 0);
      if (Reset) begin
        q.delete();
        m_stall = 0;
      end else begin
        if (in_valid && !m_ir && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush) begin
          q.delete();
        end else begin
          if (m_ov && out_ready) void'(q.pop_front());
          if (in_valid && m_ir) q.push_back(in_data);
        end
      end

      tick();
      chk($sformatf("rnd%0d out_valid", c), {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk($sformatf("rnd%0d in_ready", c), {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk($sformatf("rnd%0d occupancy", c), {30'b0, occupancy}, 32'(q.size()));
      if (q.size() > 0) chk($sformatf("rnd%0d out_data", c), {16'b0, out_data}, {16'b0, q[0]});
`ifdef REG_SLICE_STATS_EN
      chk($sformatf("rnd%0d stall_cnt", c), stall_cnt, m_stall);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_slice_skid.md
Name: reg_slice_skid

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries in the datapath, e.g. the A/B operand latches and IR/MDR.
- Generalises the fixed 32-bit latch-every-cycle register with three additions: valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush for pipeline squash.
- Breaks the combinational ready path: in_ready is purely registered.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on Reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash; drops all held entries.
- in_data  input  WIDTH  upstream payload.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  slice can accept; registered output.
- out_data  output  WIDTH  downstream payload; driven directly from the main register.
- out_valid  output  1  main register holds a valid entry.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Reset: synchronous, active-high; clock clk.
- Reset sampled high: state=ST_EMPTY; main and skid data = RESET_VAL; out_valid=0; occupancy=0; in_ready=1 from the next cycle.
- Priority: Reset > flush > handshake.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- State encoding: ST_EMPTY (occ 0), ST_ONE (main full, occ 1), ST_TWO (main + skid full, occ 2).
- ST_EMPTY:
  - in_valid: main<=in_data, go to ST_ONE.
  - otherwise stay.
- ST_ONE:
  - in_valid & out_ready: main<=in_data, stay. Throughput 1/cycle.
  - in_valid & !out_ready: skid<=in_data, go to ST_TWO.
  - !in_valid & out_ready: go to ST_EMPTY.
  - neither: hold.
- ST_TWO:
  - in_ready=0, so no in-transfer.
  - out_ready: main<=skid, go to ST_ONE.
  - otherwise hold.
- Ready and valid outputs:
  - in_ready = (next state != ST_TWO), registered. It is 0 exactly while in ST_TWO.
  - out_valid = (state != ST_EMPTY).
- Latency: an in-transfer at edge N gives out_valid=1 with that data after edge N; 1 cycle min.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Stability: out_data is stable while out_valid & !out_ready; in_data changes are ignored when in_ready=0.
- Flush:
  - Next state ST_EMPTY; an in-transfer or out-transfer in the same cycle is discarded.
  - Data registers keep their contents; only valids clear.
  - in_ready=1 next cycle.
- Reset mid-transfer: all entries lost, no partial update.
- occupancy never exceeds 2; there is no overflow path because in_ready gates writes.

Optional Feature:
- Macro REG_SLICE_STATS_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments on each cycle with in_valid & !in_ready & !flush.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by Reset only; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package reg_slice_pkg:
  - State type with ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Constant OCC_W=2.
- Sub-module reg_slice_stage:
  - Enabled WIDTH-bit data register with load enable and synchronous Reset to RESET_VAL.
  - Instantiated twice (main, skid).
- Control FSM lives in the top.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, release -> out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL.
- Streaming: in_valid=1 with 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Backpressure skid: hold 0xA0 in main, out_ready=0, send 0xB0 -> occupancy=2, in_ready=0 next cycle. Then out_ready=1 -> outputs 0xA0 then 0xB0, in_ready returns 1 after the first out-transfer.
- Flush with both entries full, plus in_valid=1 with 0xCC in the same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xCC never appears at the output.
- Reset mid-stream: Reset in ST_TWO -> next cycle ST_EMPTY, out_data=RESET_VAL; stream 0x55 after release and observe it 1 cycle later.
- REG_SLICE_STATS_EN: in ST_TWO with in_valid=1 for 5 cycles -> stall_cnt=5. Then flush -> stall_cnt stays 5. Then Reset -> stall_cnt=0.
